// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle CPU core.
// Sequences fetch / decode / operand-fetch / execute over a single
// request/ready memory port. Four general registers, Z and C flags,
// a sticky HALT state and a combinational register debug read port.
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-low reset
//   run        start request, sampled only in IDLE
//   mem_req    memory access request
//   mem_we     1 = write, 0 = read (valid while mem_req = 1)
//   mem_addr   access address (AW bits)
//   mem_wdata  store data (DW bits)
//   mem_rdata  read data, valid when mem_ready = 1
//   mem_ready  access completes in any cycle with mem_req & mem_ready
//   halted     core is in HALT
//   pc_out     current program counter
//   zflag      zero flag
//   cflag      carry / borrow flag
//   dbg_sel    register index for the debug port
//   dbg_reg    R[dbg_sel], combinational
module cpu_core_p #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int NREG = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halted,
    output logic [AW-1:0] pc_out,
    output logic          zflag,
    output logic          cflag,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_reg
);

    // Memory words needed to hold one address operand.
    localparam int AWORDS = (AW + DW - 1) / DW;
    localparam int TW     = AWORDS * DW;
    localparam int WCW    = (AWORDS > 1) ? $clog2(AWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPER, S_EXEC, S_MEM, S_HALT
    } state_t;

    state_t           state;
    logic [AW-1:0]    pc;
    logic [DW-1:0]    regs [NREG];
    logic [7:0]       ir;
    logic [TW-1:0]    tr;
    logic [WCW-1:0]   wcnt;
    logic             zf;
    logic             cf;

    logic [3:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic             has_oper;
    logic [WCW-1:0]   wlast;
    logic             jump_taken;
    logic [AW-1:0]    pc_inc;
    logic [DW:0]      alu_res;
    logic             alu_zero;

    assign op       = ir[7:4];
    assign rd       = ir[3:2];
    assign rs       = ir[1:0];
    assign has_oper = (op == 4'h1) || (op == 4'h2) || (op == 4'h3) ||
                      (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    // MVI carries one data word; every other operand is an address.
    assign wlast    = (op == 4'h3) ? '0 : WCW'(AWORDS - 1);
    assign jump_taken = (op == 4'hC) || (op == 4'hD && zf) || (op == 4'hE && !zf);
    assign pc_inc   = pc + AW'(1);

    // ALU result is DW+1 bits wide; bit DW is carry out (ADD/INC) or
    // borrow (SUB, set exactly when rd < rs).
    always_comb begin
        alu_res = '0;
        case (op)
            4'h5: alu_res = {1'b0, regs[rd]} + {1'b0, regs[rs]};
            4'h6: alu_res = {1'b0, regs[rd]} - {1'b0, regs[rs]};
            4'h7: alu_res = {1'b0, regs[rd] & regs[rs]};
            4'h8: alu_res = {1'b0, regs[rd] | regs[rs]};
            4'h9: alu_res = {1'b0, regs[rd] ^ regs[rs]};
            4'hA: alu_res = {1'b0, ~regs[rd]};
            4'hB: alu_res = {1'b0, regs[rd]} + (DW+1)'(1);
            default: alu_res = '0;
        endcase
    end
    assign alu_zero = (alu_res[DW-1:0] == '0);

    // Memory port outputs are registered and only change on a completed
    // access or a state change, so they stay stable across stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            ir        <= '0;
            tr        <= '0;
            wcnt      <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata[7:0];
                        pc      <= pc_inc;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (has_oper) begin
                        state    <= S_OPER;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        wcnt     <= '0;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_OPER: begin
                    if (mem_ready) begin
                        // Operand words arrive little-endian.
                        tr[int'(wcnt)*DW +: DW] <= mem_rdata;
                        pc <= pc_inc;
                        if (wcnt == wlast) begin
                            mem_req <= 1'b0;
                            state   <= S_EXEC;
                        end else begin
                            wcnt     <= wcnt + 1'b1;
                            mem_addr <= pc_inc;
                        end
                    end
                end
                S_EXEC: begin
                    state    <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    case (op)
                        4'h1, 4'h2: begin
                            state     <= S_MEM;
                            mem_we    <= (op == 4'h2);
                            mem_addr  <= tr[AW-1:0];
                            mem_wdata <= regs[rd];
                        end
                        4'h3: regs[rd] <= tr[DW-1:0];
                        4'h4: regs[rd] <= regs[rs];
                        4'h5, 4'h6, 4'hB: begin
                            regs[rd] <= alu_res[DW-1:0];
                            zf       <= alu_zero;
                            cf       <= alu_res[DW];
                        end
                        4'h7, 4'h8, 4'h9, 4'hA: begin
                            regs[rd] <= alu_res[DW-1:0];
                            zf       <= alu_zero;
                            cf       <= 1'b0;
                        end
                        4'hC, 4'hD, 4'hE: begin
                            if (jump_taken) begin
                                pc       <= tr[AW-1:0];
                                mem_addr <= tr[AW-1:0];
                            end
                        end
                        4'hF: begin
                            state   <= S_HALT;
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (!mem_we) regs[rd] <= mem_rdata;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pc_out  = pc;
    assign zflag   = zf;
    assign cflag   = cf;
    assign dbg_reg = regs[dbg_sel];

endmodule

// File: tb/tb_cpu_core_p.sv
// Directed bench for cpu_core_p: an 8-bit default build and a 16-bit
// data build, each with its own bench memory on the mem_* port.
module tb_cpu_core_p;

    logic        clk;
    int          checks;
    int          errors;

    // ---------------- 8-bit build ----------------
    logic        rst8, run8, ready8;
    logic        req8, we8, halted8, z8, c8;
    logic [15:0] addr8, pc8;
    logic [7:0]  wdata8, rdata8, dbg8;
    logic [1:0]  sel8;
    logic [7:0]  prog8 [65536];
    int          wr_cnt8;
    logic        wr_valid8;
    logic [15:0] last_waddr8;
    logic [7:0]  last_wdata8;
    logic [15:0] rd_log [$];

    // ---------------- 16-bit build ----------------
    logic        rst16, run16, ready16;
    logic        req16, we16, halted16, z16, c16;
    logic [15:0] addr16, pc16;
    logic [15:0] wdata16, rdata16, dbg16;
    logic [1:0]  sel16;
    logic [15:0] prog16 [65536];

    cpu_core_p #(.DW(8), .AW(16)) u_dut (
        .clk(clk), .rst(rst8), .run(run8),
        .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ready(ready8),
        .halted(halted8), .pc_out(pc8), .zflag(z8), .cflag(c8),
        .dbg_sel(sel8), .dbg_reg(dbg8)
    );

    cpu_core_p #(.DW(16), .AW(16)) u_dut16 (
        .clk(clk), .rst(rst16), .run(run16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_rdata(rdata16), .mem_ready(ready16),
        .halted(halted16), .pc_out(pc16), .zflag(z16), .cflag(c16),
        .dbg_sel(sel16), .dbg_reg(dbg16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program image plus a one-entry overlay holding the last store.
    assign rdata8  = (wr_valid8 && addr8 == last_waddr8) ? last_wdata8 : prog8[addr8];
    assign rdata16 = prog16[addr16];

    always @(posedge clk) begin
        if (!rst8) begin
            wr_cnt8   <= 0;
            wr_valid8 <= 1'b0;
            rd_log.delete();
        end else if (req8 && ready8) begin
            if (we8) begin
                wr_cnt8     <= wr_cnt8 + 1;
                wr_valid8   <= 1'b1;
                last_waddr8 <= addr8;
                last_wdata8 <= wdata8;
            end else begin
                rd_log.push_back(addr8);
            end
        end
    end

    task automatic do_reset8();
        @(negedge clk);
        rst8 = 1'b0; run8 = 1'b0; ready8 = 1'b1; sel8 = 2'd0;
        for (int i = 0; i < 65536; i++) prog8[i] = 8'h00;
        @(negedge clk);
        rst8 = 1'b1;
    endtask

    // Raise run, wait for the first fetch, then count cycles to halted.
    task automatic start_and_time8(output int cycles);
        int w;
        cycles = -1;
        w = 0;
        run8 = 1'b1;
        while (req8 !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (req8 === 1'b1) begin
            cycles = 0;
            while (halted8 !== 1'b1 && cycles < 1000) begin
                @(negedge clk);
                cycles++;
            end
            if (halted8 !== 1'b1) cycles = -1;
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b0; run8 = 1'b0; ready8 = 1'b1; sel8 = 2'd0;
        @(negedge clk);
        checks++;
        if ({req8, we8, halted8, z8, c8} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl req/we/halt/z/c got %b want 00000", {req8, we8, halted8, z8, c8});
        end
        checks++;
        if (addr8 !== 16'h0 || wdata8 !== 8'h0 || pc8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus addr %h wdata %h pc %h want 0", addr8, wdata8, pc8);
        end
        for (int r = 0; r < 4; r++) begin
            sel8 = 2'(r);
            #1;
            checks++;
            if (dbg8 !== 8'h00) begin
                errors++;
                $display("FAIL reset_R%0d got %h want 00", r, dbg8);
            end
        end
    endtask

    task automatic test_mvi_halt();
        int cyc;
        do_reset8();
        prog8[0] = 8'h30; prog8[1] = 8'h2A; prog8[2] = 8'hF0;
        start_and_time8(cyc);
        checks++;
        if (cyc !== 7) begin
            errors++;
            $display("FAIL mvi_halt_cycles got %0d want 7", cyc);
        end
        sel8 = 2'd0;
        #1;
        checks++;
        if (dbg8 !== 8'h2A) begin
            errors++;
            $display("FAIL mvi_R0 got %h want 2a", dbg8);
        end
        checks++;
        if (pc8 !== 16'h0003) begin
            errors++;
            $display("FAIL mvi_halt_pc got %h want 0003", pc8);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (halted8 !== 1'b1 || req8 !== 1'b0 || pc8 !== 16'h0003) begin
            errors++;
            $display("FAIL halt_sticky halted %b req %b pc %h want 1 0 0003", halted8, req8, pc8);
        end
    endtask

    task automatic test_add_jumps();
        int cyc;
        logic [15:0] exp_rd [12];
        exp_rd = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7,
                   16'h10, 16'h11, 16'h12, 16'h13};
        do_reset8();
        prog8[0] = 8'h30; prog8[1] = 8'hFF;            // MVI R0, FF
        prog8[2] = 8'h34; prog8[3] = 8'h01;            // MVI R1, 01
        prog8[4] = 8'h51;                              // ADD R0, R1
        prog8[5] = 8'hD0; prog8[6] = 8'h10; prog8[7] = 8'h00;      // JMPZ 0010
        prog8[16] = 8'hE0; prog8[17] = 8'h00; prog8[18] = 8'h02;   // JPNZ 0200
        prog8[19] = 8'hF0;
        start_and_time8(cyc);
        checks++;
        if (cyc !== 24) begin
            errors++;
            $display("FAIL add_jump_cycles got %0d want 24", cyc);
        end
        sel8 = 2'd0;
        #1;
        checks++;
        if (dbg8 !== 8'h00 || z8 !== 1'b1 || c8 !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap R0 %h Z %b C %b want 00 1 1", dbg8, z8, c8);
        end
        checks++;
        if (pc8 !== 16'h0014) begin
            errors++;
            $display("FAIL jump_final_pc got %h want 0014", pc8);
        end
        checks++;
        if (rd_log.size() !== 12) begin
            errors++;
            $display("FAIL read_count got %0d want 12", rd_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (rd_log[i] !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL read_addr[%0d] got %h want %h", i, rd_log[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_stac_ldac();
        int cyc;
        do_reset8();
        prog8[0] = 8'h34; prog8[1] = 8'h01;                        // MVI R1, 01
        prog8[2] = 8'h24; prog8[3] = 8'h34; prog8[4] = 8'h12;      // STAC R1, 1234
        prog8[5] = 8'h18; prog8[6] = 8'h34; prog8[7] = 8'h12;      // LDAC R2, 1234
        prog8[8] = 8'hF0;
        start_and_time8(cyc);
        checks++;
        if (cyc !== 19) begin
            errors++;
            $display("FAIL mem_cycles got %0d want 19", cyc);
        end
        checks++;
        if (wr_cnt8 !== 1 || last_waddr8 !== 16'h1234 || last_wdata8 !== 8'h01) begin
            errors++;
            $display("FAIL stac_write count %0d addr %h data %h want 1 1234 01",
                     wr_cnt8, last_waddr8, last_wdata8);
        end
        sel8 = 2'd2;
        #1;
        checks++;
        if (dbg8 !== 8'h01) begin
            errors++;
            $display("FAIL ldac_R2 got %h want 01", dbg8);
        end
        checks++;
        if (pc8 !== 16'h0009 || z8 !== 1'b0 || c8 !== 1'b0) begin
            errors++;
            $display("FAIL mem_pc_flags pc %h Z %b C %b want 0009 0 0", pc8, z8, c8);
        end
    endtask

    task automatic test_stall();
        int cyc;
        do_reset8();
        prog8[0] = 8'h00; prog8[1] = 8'hF0;
        ready8 = 1'b0;
        run8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req8 !== 1'b1 || addr8 !== 16'h0 || pc8 !== 16'h0) begin
                errors++;
                $display("FAIL stall_hold[%0d] req %b addr %h pc %h want 1 0000 0000", i, req8, addr8, pc8);
            end
        end
        ready8 = 1'b1;
        @(negedge clk);
        checks++;
        if (req8 !== 1'b0 || pc8 !== 16'h0001) begin
            errors++;
            $display("FAIL stall_release req %b pc %h want 0 0001", req8, pc8);
        end
        start_and_time8(cyc);
        checks++;
        if (halted8 !== 1'b1 || pc8 !== 16'h0002) begin
            errors++;
            $display("FAIL stall_halt halted %b pc %h want 1 0002", halted8, pc8);
        end
    endtask

    task automatic test_sub_not_inc();
        int cyc;
        // SUB 03 - 05
        do_reset8();
        prog8[0] = 8'h30; prog8[1] = 8'h03; prog8[2] = 8'h34; prog8[3] = 8'h05;
        prog8[4] = 8'h61; prog8[5] = 8'hF0;
        start_and_time8(cyc);
        sel8 = 2'd0;
        #1;
        checks++;
        if (dbg8 !== 8'hFE || c8 !== 1'b1 || z8 !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow R0 %h C %b Z %b want fe 1 0", dbg8, c8, z8);
        end
        // ADD sets C, then NOT 00 clears it
        do_reset8();
        prog8[0] = 8'h30; prog8[1] = 8'hFF; prog8[2] = 8'h34; prog8[3] = 8'h01;
        prog8[4] = 8'h51; prog8[5] = 8'hA0; prog8[6] = 8'hF0;
        start_and_time8(cyc);
        sel8 = 2'd0;
        #1;
        checks++;
        if (dbg8 !== 8'hFF || c8 !== 1'b0 || z8 !== 1'b0) begin
            errors++;
            $display("FAIL not_clears_c R0 %h C %b Z %b want ff 0 0", dbg8, c8, z8);
        end
        // INC FF wraps
        do_reset8();
        prog8[0] = 8'h38; prog8[1] = 8'hFF; prog8[2] = 8'hB8; prog8[3] = 8'hF0;
        start_and_time8(cyc);
        sel8 = 2'd2;
        #1;
        checks++;
        if (dbg8 !== 8'h00 || c8 !== 1'b1 || z8 !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap R2 %h C %b Z %b want 00 1 1", dbg8, c8, z8);
        end
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL inc_cycles got %0d want 10", cyc);
        end
    endtask

    task automatic test_dw16();
        int w;
        @(negedge clk);
        rst16 = 1'b0; run16 = 1'b0; ready16 = 1'b1; sel16 = 2'd0;
        for (int i = 0; i < 65536; i++) prog16[i] = 16'h0000;
        prog16[0] = 16'hABC0;      // JUMP, upper byte ignored
        prog16[1] = 16'h0005;
        prog16[5] = 16'h00F0;
        @(negedge clk);
        rst16 = 1'b1; run16 = 1'b1;
        @(negedge clk);
        checks++;
        if (req16 !== 1'b1 || addr16 !== 16'h0) begin
            errors++;
            $display("FAIL w16_first_fetch req %b addr %h want 1 0000", req16, addr16);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (req16 !== 1'b1 || addr16 !== 16'h0005 || pc16 !== 16'h0005) begin
            errors++;
            $display("FAIL w16_jump_4cyc req %b addr %h pc %h want 1 0005 0005", req16, addr16, pc16);
        end
        w = 0;
        while (halted16 !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (halted16 !== 1'b1 || pc16 !== 16'h0006) begin
            errors++;
            $display("FAIL w16_halt halted %b pc %h want 1 0006", halted16, pc16);
        end
        // Reset during operand fetch
        rst16 = 1'b0; run16 = 1'b0;
        @(negedge clk);
        rst16 = 1'b1; run16 = 1'b1;
        @(negedge clk);          // FETCH
        @(negedge clk);          // DECODE
        ready16 = 1'b0;
        @(negedge clk);          // OPER, stalled
        checks++;
        if (req16 !== 1'b1 || addr16 !== 16'h0001 || pc16 !== 16'h0001) begin
            errors++;
            $display("FAIL w16_in_oper req %b addr %h pc %h want 1 0001 0001", req16, addr16, pc16);
        end
        #2;
        rst16 = 1'b0;
        #1;
        checks++;
        if ({req16, we16, halted16, z16, c16} !== 5'b0 || addr16 !== 16'h0 ||
            pc16 !== 16'h0 || wdata16 !== 16'h0 || dbg16 !== 16'h0) begin
            errors++;
            $display("FAIL w16_async_reset ctl %b addr %h pc %h wdata %h R0 %h want all 0",
                     {req16, we16, halted16, z16, c16}, addr16, pc16, wdata16, dbg16);
        end
        @(negedge clk);
        rst16 = 1'b1; run16 = 1'b0; ready16 = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst16 = 1'b0; run16 = 1'b0; ready16 = 1'b1; sel16 = 2'd0;
        test_reset();
        test_mvi_halt();
        test_add_jumps();
        test_stac_ldac();
        test_stall();
        test_sub_not_inc();
        test_dw16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
